sp_ram_arb2: RTL and testbench
==============================

Name: sp_ram_arb2

Overview:
- Two-requester arbiter and sequencer for one single-port, read-first block RAM (1-cycle read latency, en/we/addr/di/dout interface).
- Grants at most one access per cycle using round-robin, or fixed priority with a starvation guard.
- Returns each granted access's read data, the pre-write contents for writes, to the winning requester.
- Sits between two client engines and one RAM instance in the memory subsystem.

Parameters:
- D, 18, data width (matches RAM).
- A, 10, address width (matches RAM).
- STARVE_MAX, 4, consecutive port-1 losses in priority mode before port 1 is forced; range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prio_mode  in  1  0 = round-robin, 1 = port 0 fixed priority with starvation guard.
- req_valid  in  2  per-port request valid.
- req_we  in  2  per-port write enable.
- req_addr  in  2*A  per-port address, port i at bits [i*A +: A].
- req_wdata  in  2*D  per-port write data, port i at bits [i*D +: D].
- req_ready  out  2  per-port grant; handshake = valid & ready.
- rsp_valid  out  2  per-port response strobe.
- rsp_rdata  out  D  response data, qualified by rsp_valid.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  A  RAM address.
- ram_di  out  D  RAM write data.
- ram_dout  in  D  RAM read data, valid 1 cycle after ram_en.

Behaviour:
- Grant is combinational from req_valid and internal state; req_ready is one-hot or zero.
- req_ready never depends on req_ready of the same port; no combinational path from rsp to req.
- Round-robin (prio_mode=0):
  - Only one port valid: grant it.
  - Both valid: grant the port not granted last.
  - last_grant register updates only on a handshake.
  - Reset value last_grant=1, so port 0 wins the first contention.
- Priority (prio_mode=1):
  - Port 0 wins contention unless starve_cnt == STARVE_MAX; then port 1 wins.
  - starve_cnt (4-bit): +1 when port 1 is valid and not granted; cleared when port 1 is granted or port 1 is not valid; saturates at STARVE_MAX.
  - starve_cnt is cleared while prio_mode=0.
  - prio_mode may change any cycle and takes effect the same cycle.
- RAM drive (combinational from the granted port):
  - ram_en = any handshake.
  - ram_we, ram_addr, ram_di are muxed from the granted port.
  - With no grant: ram_en=0, ram_we=0, ram_addr=0, ram_di=0.
- Response:
  - rsp_valid[i] is registered: asserted exactly 1 cycle after port i's handshake, for 1 cycle.
  - A response is issued for both reads and writes.
  - rsp_rdata = ram_dout when any rsp_valid is set, else 0.
  - No response backpressure; requesters must accept.
- Back-to-back: one handshake per cycle is sustained. A response in cycle n+1 coexists with a new grant in n+1.
- Same-address hazard: a write at n followed by a read of the same address at n+1 returns the new data. A write at n returns the old data (read-first).
- Reset values: rsp_valid=0, last_grant=1, starve_cnt=0, hence rsp_rdata=0.
- Reset mid-operation: a pending response is dropped (rsp_valid forced 0). The RAM write already issued stands.
- An unmatched request stays pending: no grant, no side effect. Requesters hold valid and fields stable until ready.

Decomposition:
- Package sp_ram_arb_pkg:
  - Port index constants P0=0, P1=1.
  - STARVE_W=4.
  - Mode encodings MODE_RR=0, MODE_PRIO=1.
- Sub-module arb2_pick: combinational winner select from valid[1:0], mode, last_grant and starve flag.
- The top holds last_grant, starve_cnt, the response pipeline and the RAM muxing.
- The RAM itself is instantiated outside this block.

Test Plan:
- Reset, then port 0 write addr 5 = 0x155 → ram_en=1, ram_we=1, ram_addr=5; next cycle rsp_valid=01. Then port 1 reads addr 5 → rsp_valid=10, rsp_rdata=0x155.
- Both ports valid continuously, prio_mode=0 → grants alternate P0,P1,P0,P1, and rsp_valid alternates 01,10 with 1-cycle lag.
- prio_mode=1, both valid, STARVE_MAX=4 → P0 granted 4 cycles, P1 granted on the 5th, starve_cnt back to 0, pattern repeats.
- Port 0 writes 0x0AA at addr 3 while it holds 0x111 → rsp_rdata=0x111. Immediate port 1 read of addr 3 → 0x0AA.
- rst_n asserted low the cycle after a handshake → rsp_valid stays 0 and req_ready=00. After release, first contention is won by P0.
- No requests for 10 cycles → ram_en=0, rsp_valid=00, rsp_rdata=0 throughout.

Source files
------------

// File: rtl/sp_ram_arb_pkg.sv
// Shared constants for the two-port single-port-RAM arbiter.
// Port indices, starvation counter width and arbitration mode encodings.
package sp_ram_arb_pkg;
  localparam logic P0        = 1'b0;
  localparam logic P1        = 1'b1;
  localparam int   STARVE_W  = 4;
  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_PRIO = 1'b1;
endpackage

// File: rtl/sp_ram_arb2_pick.sv
// Combinational winner select for two requesters.
// Round-robin uses last_grant; priority mode favours port 0 unless port 1 is starving.
module arb2_pick
  import sp_ram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       mode,
  input  logic       last_grant,
  input  logic       starve,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (mode == MODE_PRIO) grant = starve ? 2'b10 : 2'b01;
        else                   grant = (last_grant == P1) ? 2'b01 : 2'b10;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sp_ram_arb2.sv
// Two-requester arbiter/sequencer for one read-first single-port RAM.
// Grants one access per cycle and routes the 1-cycle-late read data back to the winner.
module sp_ram_arb2
  import sp_ram_arb_pkg::*;
#(
  parameter int D          = 18,
  parameter int A          = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           prio_mode,
  input  logic [1:0]     req_valid,
  input  logic [1:0]     req_we,
  input  logic [2*A-1:0] req_addr,
  input  logic [2*D-1:0] req_wdata,
  output logic [1:0]     req_ready,
  output logic [1:0]     rsp_valid,
  output logic [D-1:0]   rsp_rdata,
  output logic           ram_en,
  output logic           ram_we,
  output logic [A-1:0]   ram_addr,
  output logic [D-1:0]   ram_di,
  input  logic [D-1:0]   ram_dout
);

  logic                last_grant;
  logic [STARVE_W-1:0] starve_cnt;
  logic                starve;
  logic [1:0]          pick;
  logic [1:0]          grant;
  logic [1:0]          rsp_vld_p1;

  assign starve = (starve_cnt == STARVE_W'(STARVE_MAX));

  arb2_pick u_pick (
    .valid      (req_valid),
    .mode       (prio_mode),
    .last_grant (last_grant),
    .starve     (starve),
    .grant      (pick)
  );

  // No grants while reset is held, so nothing reaches the RAM during reset.
  assign grant     = rst_n ? pick : 2'b00;
  assign req_ready = grant;
  assign ram_en    = |grant;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (grant[P1]) begin
      ram_we   = req_we[P1];
      ram_addr = req_addr[A +: A];
      ram_di   = req_wdata[D +: D];
    end else if (grant[P0]) begin
      ram_we   = req_we[P0];
      ram_addr = req_addr[0 +: A];
      ram_di   = req_wdata[0 +: D];
    end
  end

  // Stage p0 -> p1: handshake becomes the response strobe alongside RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= P1;
      starve_cnt <= '0;
      rsp_vld_p1 <= 2'b00;
    end else begin
      rsp_vld_p1 <= grant;
      if (|grant) last_grant <= grant[P1];
      if (prio_mode == MODE_RR || !req_valid[P1] || grant[P1])
        starve_cnt <= '0;
      else if (!starve)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign rsp_valid = rsp_vld_p1;
  assign rsp_rdata = (|rsp_vld_p1) ? ram_dout : '0;

endmodule

// File: tb/tb_sp_ram_arb2.sv
// Directed testbench for sp_ram_arb2 with a behavioural read-first RAM.
module tb_sp_ram_arb2;
  localparam int D = 18;
  localparam int A = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           prio_mode;
  logic [1:0]     req_valid;
  logic [1:0]     req_we;
  logic [2*A-1:0] req_addr;
  logic [2*D-1:0] req_wdata;
  logic [1:0]     req_ready;
  logic [1:0]     rsp_valid;
  logic [D-1:0]   rsp_rdata;
  logic           ram_en;
  logic           ram_we;
  logic [A-1:0]   ram_addr;
  logic [D-1:0]   ram_di;
  logic [D-1:0]   ram_dout;

  int checks = 0;
  int errors = 0;

  logic [D-1:0] mem [0:(1<<A)-1];

  always #5 clk = ~clk;

  sp_ram_arb2 #(.D(D), .A(A), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prio_mode (prio_mode),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_di    (ram_di),
    .ram_dout  (ram_dout)
  );

  // Read-first RAM, 1-cycle read latency
  initial begin
    for (int i = 0; i < (1<<A); i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_di;
    end
  end

  // Apply inputs at the falling edge, then settle before checking.
  task automatic set_req(input logic [1:0] v, input logic [1:0] we,
                         input logic [A-1:0] a0, input logic [A-1:0] a1,
                         input logic [D-1:0] d0, input logic [D-1:0] d1);
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; prio_mode = 1'b0;
    set_req(2'b11, 2'b00, 10'd1, 10'd2, '0, '0);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (rsp_rdata !== 18'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    set_req(2'b01, 2'b01, 10'd5, 10'd0, 18'h155, 18'h0);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b want 01", req_ready); end
    checks++; if ({ram_en, ram_we} !== 2'b11) begin errors++; $display("FAIL wr_en_we: got %b want 11", {ram_en, ram_we}); end
    checks++; if (ram_addr !== 10'd5) begin errors++; $display("FAIL wr_addr: got %0d want 5", ram_addr); end
    checks++; if (ram_di !== 18'h155) begin errors++; $display("FAIL wr_di: got %h want 155", ram_di); end
    set_req(2'b10, 2'b00, 10'd0, 10'd5, '0, '0);
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL wr_rsp: got %b want 01", rsp_valid); end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_ready: got %b want 10", req_ready); end
    checks++; if ({ram_we, ram_addr} !== {1'b0, 10'd5}) begin errors++; $display("FAIL rd_ram: got we=%b addr=%0d want we=0 addr=5", ram_we, ram_addr); end
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rd_rsp: got %b want 10", rsp_valid); end
    checks++; if (rsp_rdata !== 18'h155) begin errors++; $display("FAIL rd_data: got %h want 155", rsp_rdata); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    prev_g = 2'b00;
    prio_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(2'b11, 2'b00, 10'd10, 10'd20, '0, '0);
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, exp_g); end
      if (i > 0) begin
        checks++; if (rsp_valid !== prev_g) begin errors++; $display("FAIL rr_rsp[%0d]: got %b want %b", i, rsp_valid, prev_g); end
      end
      prev_g = exp_g;
    end
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rr_rsp_last: got %b want 10", rsp_valid); end
  endtask

  task automatic test_priority();
    logic [1:0] exp_g;
    prio_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(2'b11, 2'b00, 10'd10, 10'd20, '0, '0);
      exp_g = (i % 5 == 4) ? 2'b10 : 2'b01;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL prio_grant[%0d]: got %b want %b", i, req_ready, exp_g); end
    end
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL prio_rsp_last: got %b want 10", rsp_valid); end
    prio_mode = 1'b0;
  endtask

  task automatic test_hazard();
    set_req(2'b01, 2'b01, 10'd3, 10'd0, 18'h111, '0);
    set_req(2'b01, 2'b01, 10'd3, 10'd0, 18'h0AA, '0);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL hz_ready: got %b want 01", req_ready); end
    set_req(2'b10, 2'b00, 10'd0, 10'd3, '0, '0);
    checks++; if ({rsp_valid, rsp_rdata} !== {2'b01, 18'h111}) begin errors++; $display("FAIL hz_old: got %b/%h want 01/111", rsp_valid, rsp_rdata); end
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    checks++; if ({rsp_valid, rsp_rdata} !== {2'b10, 18'h0AA}) begin errors++; $display("FAIL hz_new: got %b/%h want 10/0aa", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    set_req(2'b01, 2'b01, 10'd7, 10'd0, 18'h3C3, '0);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_ready: got %b want 01", req_ready); end
    set_req(2'b11, 2'b00, 10'd7, 10'd8, '0, '0);
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_rsp: got %b want 00", rsp_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rm_ready_rst: got %b want 00", req_ready); end
    @(negedge clk);
    #1;
    checks++; if ({rsp_valid, ram_en} !== 3'b000) begin errors++; $display("FAIL rm_hold: got %b want 000", {rsp_valid, ram_en}); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_win: got %b want 01", req_ready); end
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    checks++; if ({rsp_valid, rsp_rdata} !== {2'b01, 18'h3C3}) begin errors++; $display("FAIL rm_write_kept: got %b/%h want 01/3c3", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_idle();
    set_req(2'b00, 2'b00, 10'd9, 10'd9, 18'h3FFFF, 18'h3FFFF);
    for (int i = 0; i < 10; i++) begin
      set_req(2'b00, 2'b11, 10'd9, 10'd9, 18'h3FFFF, 18'h3FFFF);
      checks++;
      if ({ram_en, ram_we, ram_addr, ram_di, rsp_valid, rsp_rdata} !== '0) begin
        errors++;
        $display("FAIL idle[%0d]: got en=%b we=%b addr=%h di=%h rv=%b rd=%h want all 0",
                 i, ram_en, ram_we, ram_addr, ram_di, rsp_valid, rsp_rdata);
      end
    end
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_priority();
    test_hazard();
    test_reset_mid();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
